// File: rtl/ysyx_25040109_csr_pkg.sv
// rtl/ysyx_25040109_csr_pkg.sv - shared CSR addresses, mstatus layout and cause codes
// Contents: CSR address constants, mstatus bit positions, mstatus reset value,
//           M-mode ecall cause code, and an address-decode helper.
package ysyx_25040109_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  // mtvec/mepc only hold 4-byte aligned addresses
  localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
      CSR_MVENDORID, CSR_MARCHID: csr_implemented = 1'b1;
      default:                    csr_implemented = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040109_csr_counter64.sv
// rtl/ysyx_25040109_csr_counter64.sv - 64-bit counter with independently writable halves
// Ports: clk, rst (sync, active-high); inc = count this cycle; wr_lo/wr_hi = load
//        that half from wdata (blocks the increment, other half held); lo/hi = value.
module ysyx_25040109_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lo <= 32'd0;
      hi <= 32'd0;
    end else if (wr_lo) begin
      lo <= wdata;
    end else if (wr_hi) begin
      hi <= wdata;
    end else if (inc) begin
      // single 64-bit add carries low into high and wraps to zero at the top
      {hi, lo} <= {hi, lo} + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_25040109_csr_file.sv
// rtl/ysyx_25040109_csr_file.sv - machine-mode CSR file with trap state and counters
// Ports: clk, rst (sync, active-high); csr_addr/csr_rdata combinational read;
//        csr_we/csr_wdata write; csr_illegal flags bad access; ecall_valid with
//        trap_pc/trap_cause enters a trap; mret_valid returns; inst_retire counts
//        retired instructions; mepc_out/mtvec_out expose the trap registers.
module ysyx_25040109_csr_file
  import ysyx_25040109_csr_pkg::*;
#(
  parameter logic [31:0] MVENDORID = 32'h7973_7978,
  parameter logic [31:0] MARCHID   = 32'd25040109,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  output logic [31:0] csr_rdata,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic        csr_illegal,
  input  logic        ecall_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_valid,
  input  logic        inst_retire,
  output logic [31:0] mepc_out,
  output logic [31:0] mtvec_out
);

  logic        mie;
  logic        mpie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mstatus_rd;
  logic [31:0] mcycle_lo, mcycle_hi;
  logic [31:0] minstret_lo, minstret_hi;

  // trap events take precedence, so a software write in the same cycle is dropped
  logic csr_wr;
  assign csr_wr = csr_we && !ecall_valid && !mret_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      mie      <= MSTATUS_RST[MSTATUS_MIE];
      mpie     <= MSTATUS_RST[MSTATUS_MPIE];
      mtvec    <= MTVEC_RST;
      mscratch <= 32'd0;
      mepc     <= 32'd0;
      mcause   <= 32'd0;
    end else if (ecall_valid) begin
      mepc   <= trap_pc & ALIGN4_MASK;
      mcause <= trap_cause;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret_valid) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie  <= csr_wdata[MSTATUS_MIE];
          mpie <= csr_wdata[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= csr_wdata & ALIGN4_MASK;
        CSR_MSCRATCH: mscratch <= csr_wdata;
        CSR_MEPC:     mepc     <= csr_wdata & ALIGN4_MASK;
        CSR_MCAUSE:   mcause   <= csr_wdata;
        default: ;
      endcase
    end
  end

  ysyx_25040109_csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_wr && (csr_addr == CSR_MCYCLE)),
    .wr_hi (csr_wr && (csr_addr == CSR_MCYCLEH)),
    .wdata (csr_wdata),
    .lo    (mcycle_lo),
    .hi    (mcycle_hi)
  );

  ysyx_25040109_csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retire),
    .wr_lo (csr_wr && (csr_addr == CSR_MINSTRET)),
    .wr_hi (csr_wr && (csr_addr == CSR_MINSTRETH)),
    .wdata (csr_wdata),
    .lo    (minstret_lo),
    .hi    (minstret_hi)
  );

  // WARL view: only MIE/MPIE are stored, MPP is hardwired to M-mode
  always_comb begin
    mstatus_rd = 32'd0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MPIE] = mpie;
    mstatus_rd[MSTATUS_MIE]  = mie;
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MSCRATCH:  csr_rdata = mscratch;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MCYCLE:    csr_rdata = mcycle_lo;
      CSR_MCYCLEH:   csr_rdata = mcycle_hi;
      CSR_MINSTRET:  csr_rdata = minstret_lo;
      CSR_MINSTRETH: csr_rdata = minstret_hi;
      CSR_MVENDORID: csr_rdata = MVENDORID;
      CSR_MARCHID:   csr_rdata = MARCHID;
      default:       csr_rdata = 32'd0;
    endcase
  end

  assign csr_illegal = !csr_implemented(csr_addr) ||
                       (csr_we && ((csr_addr == CSR_MVENDORID) || (csr_addr == CSR_MARCHID)));

  assign mepc_out  = mepc;
  assign mtvec_out = mtvec;

endmodule

// File: tb/tb_ysyx_25040109_csr_file.sv
// tb/tb_ysyx_25040109_csr_file.sv - self-checking bench for the machine-mode CSR file
module tb_ysyx_25040109_csr_file;

  localparam logic [31:0] VENDOR = 32'h7973_7978;
  localparam logic [31:0] ARCH   = 32'd25040109;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        csr_illegal;
  logic        ecall_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret_valid;
  logic        inst_retire;
  logic [31:0] mepc_out;
  logic [31:0] mtvec_out;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state, kept as whole architectural values
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_mcycle, m_minstret;

  always #5 clk = ~clk;

  ysyx_25040109_csr_file dut (
    .clk         (clk),
    .rst         (rst),
    .csr_addr    (csr_addr),
    .csr_rdata   (csr_rdata),
    .csr_we      (csr_we),
    .csr_wdata   (csr_wdata),
    .csr_illegal (csr_illegal),
    .ecall_valid (ecall_valid),
    .trap_pc     (trap_pc),
    .trap_cause  (trap_cause),
    .mret_valid  (mret_valid),
    .inst_retire (inst_retire),
    .mepc_out    (mepc_out),
    .mtvec_out   (mtvec_out)
  );

  function automatic logic model_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12};
  endfunction

  function automatic logic model_illegal(input logic [11:0] a, input logic we);
    return !model_impl(a) || (we && (a == 12'hF11 || a == 12'hF12));
  endfunction

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      12'hB02: return m_minstret[31:0];
      12'hB82: return m_minstret[63:32];
      12'hF11: return VENDOR;
      12'hF12: return ARCH;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic cyc_inc;
    logic ins_inc;
    if (rst) begin
      m_mstatus = 32'h1800; m_mtvec = 32'd0; m_mscratch = 32'd0;
      m_mepc = 32'd0; m_mcause = 32'd0; m_mcycle = 64'd0; m_minstret = 64'd0;
    end else begin
      cyc_inc = 1'b1;
      ins_inc = inst_retire;
      if (ecall_valid) begin
        m_mepc    = trap_pc & 32'hFFFF_FFFC;
        m_mcause  = trap_cause;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (mret_valid) begin
        m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (csr_we) begin
        case (csr_addr)
          12'h300: m_mstatus  = 32'h1800 | (csr_wdata & 32'h88);
          12'h305: m_mtvec    = csr_wdata & 32'hFFFF_FFFC;
          12'h340: m_mscratch = csr_wdata;
          12'h341: m_mepc     = csr_wdata & 32'hFFFF_FFFC;
          12'h342: m_mcause   = csr_wdata;
          12'hB00: begin m_mcycle[31:0]    = csr_wdata; cyc_inc = 1'b0; end
          12'hB80: begin m_mcycle[63:32]   = csr_wdata; cyc_inc = 1'b0; end
          12'hB02: begin m_minstret[31:0]  = csr_wdata; ins_inc = 1'b0; end
          12'hB82: begin m_minstret[63:32] = csr_wdata; ins_inc = 1'b0; end
          default: ;
        endcase
      end
      if (cyc_inc) m_mcycle = m_mcycle + 64'd1;
      if (ins_inc) m_minstret = m_minstret + 64'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    csr_we = 1'b0; ecall_valid = 1'b0; mret_valid = 1'b0; inst_retire = 1'b0;
    csr_wdata = 32'd0; trap_pc = 32'd0; trap_cause = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; csr_addr = 12'h300; idle();
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    csr_addr = 12'hB00; #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_mcycle: got %h expected %h", csr_rdata, 32'd0); end
    csr_addr = 12'h300; #1;
    n_checks++; if (csr_rdata !== 32'h1800) begin n_fail++; $display("FAIL reset_mstatus: got %h expected %h", csr_rdata, 32'h1800); end
    csr_addr = 12'h305; #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_mtvec: got %h expected %h", csr_rdata, 32'd0); end
    csr_addr = 12'hF11; #1;
    n_checks++; if (csr_rdata !== VENDOR) begin n_fail++; $display("FAIL reset_mvendorid: got %h expected %h", csr_rdata, VENDOR); end
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", csr_illegal); end
    n_checks++; if (mepc_out !== 32'd0) begin n_fail++; $display("FAIL reset_mepc_out: got %h expected 0", mepc_out); end
    n_checks++; if (mtvec_out !== 32'd0) begin n_fail++; $display("FAIL reset_mtvec_out: got %h expected 0", mtvec_out); end
    tick();
  endtask

  task automatic test_mtvec_write();
    csr_addr = 12'h305; csr_we = 1'b1; csr_wdata = 32'h8000_0103;
    @(negedge clk); #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mtvec_same_cycle: got %h expected %h", csr_rdata, 32'd0); end
    tick();
    idle();
    @(negedge clk); #1;
    n_checks++; if (mtvec_out !== 32'h8000_0100) begin n_fail++; $display("FAIL mtvec_out_aligned: got %h expected %h", mtvec_out, 32'h8000_0100); end
    n_checks++; if (csr_rdata !== 32'h8000_0100) begin n_fail++; $display("FAIL mtvec_read: got %h expected %h", csr_rdata, 32'h8000_0100); end
    tick();
  endtask

  task automatic test_ecall_mret();
    csr_addr = 12'h300; csr_we = 1'b1; csr_wdata = 32'h8;
    tick();
    ecall_valid = 1'b1; trap_pc = 32'h8000_0012; trap_cause = 32'd11;
    csr_addr = 12'h341; csr_we = 1'b1; csr_wdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL ecall_old_mepc: got %h expected %h", csr_rdata, 32'd0); end
    tick();
    idle();
    @(negedge clk); #1;
    n_checks++; if (csr_rdata !== 32'h8000_0010) begin n_fail++; $display("FAIL ecall_mepc: got %h expected %h", csr_rdata, 32'h8000_0010); end
    n_checks++; if (mepc_out !== 32'h8000_0010) begin n_fail++; $display("FAIL ecall_mepc_out: got %h expected %h", mepc_out, 32'h8000_0010); end
    csr_addr = 12'h342; #1;
    n_checks++; if (csr_rdata !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause: got %h expected %h", csr_rdata, 32'd11); end
    csr_addr = 12'h300; #1;
    n_checks++; if (csr_rdata !== 32'h1880) begin n_fail++; $display("FAIL ecall_mstatus: got %h expected %h", csr_rdata, 32'h1880); end
    tick();
    mret_valid = 1'b1; csr_we = 1'b1; csr_addr = 12'h340; csr_wdata = 32'h1234_5678;
    tick();
    idle();
    @(negedge clk);
    csr_addr = 12'h300; #1;
    n_checks++; if (csr_rdata !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus: got %h expected %h", csr_rdata, 32'h1888); end
    n_checks++; if (mepc_out !== 32'h8000_0010) begin n_fail++; $display("FAIL mret_mepc_out: got %h expected %h", mepc_out, 32'h8000_0010); end
    csr_addr = 12'h340; #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mret_drops_write: got %h expected %h", csr_rdata, 32'd0); end
    tick();
  endtask

  task automatic test_counters();
    csr_we = 1'b1; csr_addr = 12'hB80; csr_wdata = 32'd0;
    tick();
    csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFF;
    tick();
    idle();
    @(negedge clk);
    csr_addr = 12'hB00; #1;
    n_checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_n1_lo: got %h expected %h", csr_rdata, 32'hFFFF_FFFF); end
    csr_addr = 12'hB80; #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mcycle_n1_hi: got %h expected %h", csr_rdata, 32'd0); end
    tick();
    @(negedge clk);
    csr_addr = 12'hB00; #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mcycle_n2_lo: got %h expected %h", csr_rdata, 32'd0); end
    csr_addr = 12'hB80; #1;
    n_checks++; if (csr_rdata !== 32'd1) begin n_fail++; $display("FAIL mcycle_n2_hi: got %h expected %h", csr_rdata, 32'd1); end
    tick();
    csr_we = 1'b1; csr_addr = 12'hB02; csr_wdata = 32'd0;
    tick();
    csr_addr = 12'hB82;
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      inst_retire = (i % 2 == 0);
      tick();
    end
    inst_retire = 1'b0;
    @(negedge clk);
    csr_addr = 12'hB02; #1;
    n_checks++; if (csr_rdata !== 32'd5) begin n_fail++; $display("FAIL minstret_pulses: got %h expected %h", csr_rdata, 32'd5); end
    csr_addr = 12'hB82; #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL minstreth: got %h expected %h", csr_rdata, 32'd0); end
    tick();
  endtask

  task automatic test_readonly_illegal();
    csr_addr = 12'hF12; csr_we = 1'b1; csr_wdata = $urandom;
    @(negedge clk); #1;
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ro_write_illegal: got %b expected 1", csr_illegal); end
    tick();
    idle();
    @(negedge clk); #1;
    n_checks++; if (csr_rdata !== ARCH) begin n_fail++; $display("FAIL marchid_kept: got %h expected %h", csr_rdata, ARCH); end
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL ro_read_legal: got %b expected 0", csr_illegal); end
    csr_addr = 12'h7C0; #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL unimpl_rdata: got %h expected 0", csr_rdata); end
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL unimpl_illegal: got %b expected 1", csr_illegal); end
    tick();
  endtask

  task automatic test_reset_override();
    csr_addr = 12'h341; csr_we = 1'b1; csr_wdata = 32'h5555_5554;
    ecall_valid = 1'b1; trap_pc = 32'h1234_5678; trap_cause = 32'd11; rst = 1'b1;
    tick();
    rst = 1'b0; idle();
    @(negedge clk); #1;
    n_checks++; if (mepc_out !== 32'd0) begin n_fail++; $display("FAIL rst_override_mepc: got %h expected 0", mepc_out); end
    csr_addr = 12'h300; #1;
    n_checks++; if (csr_rdata !== 32'h1800) begin n_fail++; $display("FAIL rst_override_mstatus: got %h expected %h", csr_rdata, 32'h1800); end
    csr_addr = 12'hB00; #1;
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_override_mcycle: got %h expected 0", csr_rdata); end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] pool [14];
    logic [31:0] exp_rd;
    logic        exp_ill;
    pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
             12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'h7C0, 12'h301, 12'h000};
    for (int i = 0; i < 400; i++) begin
      csr_addr    = pool[$urandom_range(0, 13)];
      if ($urandom_range(0, 7) == 0) csr_addr = 12'($urandom);
      csr_we      = ($urandom_range(0, 1) == 1);
      csr_wdata   = $urandom;
      ecall_valid = ($urandom_range(0, 11) == 0);
      mret_valid  = ($urandom_range(0, 11) == 0);
      trap_pc     = $urandom;
      trap_cause  = ($urandom_range(0, 1) == 1) ? 32'd11 : $urandom;
      inst_retire = ($urandom_range(0, 1) == 1);
      rst         = ($urandom_range(0, 63) == 0);
      @(negedge clk); #1;
      exp_rd  = model_rd(csr_addr);
      exp_ill = model_illegal(csr_addr, csr_we);
      n_checks++; if (csr_rdata !== exp_rd) begin n_fail++; $display("FAIL rand_rdata[%0d] addr %h: got %h expected %h", i, csr_addr, csr_rdata, exp_rd); end
      n_checks++; if (csr_illegal !== exp_ill) begin n_fail++; $display("FAIL rand_illegal[%0d] addr %h: got %b expected %b", i, csr_addr, csr_illegal, exp_ill); end
      n_checks++; if (mepc_out !== m_mepc) begin n_fail++; $display("FAIL rand_mepc_out[%0d]: got %h expected %h", i, mepc_out, m_mepc); end
      n_checks++; if (mtvec_out !== m_mtvec) begin n_fail++; $display("FAIL rand_mtvec_out[%0d]: got %h expected %h", i, mtvec_out, m_mtvec); end
      tick();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_mtvec_write();
    test_ecall_mret();
    test_counters();
    test_readonly_illegal();
    test_reset_override();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
